// File: rtl/shifter_pkg.sv
// Shared shift-unit types: operation encodings and the iterative shifter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    // ALU shift operation encodings; the ALU decode imports these as well.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    // Iterative shifter control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of WIDTH bits by 0..STEP positions, log2(STEP)+1 mux stages.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amt,
    input  op_t              op,
    input  logic             fill,
    output logic [WIDTH-1:0] y
);

    // Stage k conditionally shifts by 2**k; the top stage can cover a full STEP.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] shifted;
        logic [WIDTH-1:0] dout;

        if (k == 0) begin : g_first
            assign din = x;
        end else begin : g_chain
            assign din = g_stage[k-1].dout;
        end

        if (SH < WIDTH) begin : g_part
            // Partial-width shift with op-specific fill.
            always_comb begin
                case (op)
                    OP_SLL:  shifted = {din[WIDTH-1-SH:0], {SH{1'b0}}};
                    OP_SRL:  shifted = {{SH{1'b0}}, din[WIDTH-1:SH]};
                    OP_SRA:  shifted = {{SH{fill}}, din[WIDTH-1:SH]};
                    default: shifted = {din[WIDTH-1-SH:0], din[WIDTH-1:WIDTH-SH]};
                endcase
            end
        end else begin : g_full
            // A whole-width shift leaves only fill bits, or the operand itself for a rotate.
            always_comb begin
                case (op)
                    OP_SRA:  shifted = {WIDTH{fill}};
                    OP_ROL:  shifted = din;
                    default: shifted = '0;
                endcase
            end
        end

        assign dout = amt[k] ? shifted : din;
    end

    assign y = g_stage[AMT_W-1].dout;

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter moving up to STEP bits per clock.
// Latency: max(1, ceil(shamt/STEP)) busy cycles, then a one-cycle done pulse.
// Backpressure: start honoured only in IDLE/DONE; ignored (not queued) while busy.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int AMT_W = $clog2(STEP) + 1;
    localparam int REM_W = SHAMT_W + 1;

    shift_state_t       state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;
    op_t                op_q;
    logic               sign;

    logic [REM_W-1:0]   rem_ext;
    logic [REM_W-1:0]   step_lim;
    logic [REM_W-1:0]   step_sz;
    logic [SHAMT_W-1:0] rem_next;
    logic [AMT_W-1:0]   step_amt;
    logic [WIDTH-1:0]   step_out;

    // Widen by one bit so STEP == WIDTH is representable in the comparison.
    assign rem_ext  = {1'b0, rem};
    assign step_lim = REM_W'(STEP);
    assign step_sz  = (rem_ext > step_lim) ? step_lim : rem_ext;
    assign rem_next = rem - step_sz[SHAMT_W-1:0];
    assign step_amt = AMT_W'(step_sz);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .x    (acc),
        .amt  (step_amt),
        .op   (op_q),
        .fill (sign),
        .y    (step_out)
    );

    // Control FSM with accumulator, remaining count and registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= OP_SLL;
            sign  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc   <= data;
                        rem   <= shamt;
                        op_q  <= op_t'(op);
                        sign  <= data[WIDTH-1];
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    // A zero shift amount still spends one cycle here, leaving acc untouched.
                    if (rem != '0) begin
                        acc <= step_out;
                        rem <= rem_next;
                    end
                    if (rem_next == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign result = acc;

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised barrel-shifter replacement for the processor ALU shift path. It generalises the fixed one-bit left shift into logical left, logical right, arithmetic right and rotate-left operations with a run-time shift amount. It shifts up to STEP bits per clock, trading latency for area. It sits beside the multiply/divide unit and uses the same start/done handshake, so the pipeline stalls on `busy` exactly as it does for multdiv.

## Interface

Parameters:
- WIDTH, 32, datapath width in bits; power of two, ≥ 4.
- STEP, 1, maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- data  input  WIDTH  operand; captured with start.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WIDTH  shifted value; holds until the next accepted start.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1:
  - capture data into acc, shamt into rem, op into op_q.
  - capture sign = data[WIDTH-1].
  - go to SHIFT.
- DONE with start=0: go to IDLE.
- SHIFT with rem≠0:
  - s = min(STEP, rem).
  - acc is shifted by s per op_q; rem ← rem − s.
  - if the new rem = 0, go to DONE.
- SHIFT with rem=0 (shamt was 0): go to DONE, acc unchanged.
- Shift rules per op:
  - SLL: zero fill at the LSBs.
  - SRL: zero fill at the MSBs.
  - SRA: MSBs filled with the captured sign.
  - ROL: bits leaving the MSB re-enter at the LSB.
- result is driven by acc; its value is architecturally meaningful only from done onward.
- start in SHIFT is ignored. No queueing; the requester must re-assert start.
- op and shamt are never re-sampled mid-operation.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state=IDLE, acc=0, rem=0, busy=0, done=0, result=0.
- Reset asserted mid-SHIFT aborts the operation immediately; no done is issued.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E0+L, where L = max(1, ceil(shamt/STEP)).
- busy is high for L cycles; done is high for exactly 1 cycle.
- Back-to-back: start high during the done cycle is accepted, and busy rises the next cycle, giving zero idle cycles between operations.
- Final partial step: if shamt is not a multiple of STEP, the last SHIFT cycle shifts by the remainder only.
- STEP=WIDTH: L=1 for every shamt.

## Structure

- Shared package `shifter_pkg`:
  - op encodings OP_SLL/OP_SRL/OP_SRA/OP_ROL.
  - state enum `shift_state_t`.
  - ALU decode also imports the op encodings.
- One sub-module, `shift_step`: a combinational shift of WIDTH bits by amount 0..STEP with op and fill inputs, built as log2(STEP)+1 mux stages.
- `iter_shifter` holds the FSM, acc, rem and the handshake.

## Test plan

- WIDTH=32, STEP=1, SLL, data=0x0000_0001, shamt=31 → busy for 31 cycles, done pulse, result=0x8000_0000.
- STEP=4, SRA, data=0x8000_00F0, shamt=6 → L=2 (4+2), result=0xFE00_0003.
- STEP=4, ROL, data=0x8000_0001, shamt=0 → L=1, result=0x8000_0001; then SRL shamt=1 on the same data → result=0x4000_0000.
- Back-to-back: start re-asserted in the done cycle with SLL, data=0x1, shamt=4, STEP=2 → busy rises the next cycle, done 2 cycles later, result=0x10.
- reset_n pulsed low mid-SHIFT (SRL, shamt=20, STEP=1, cycle 7) → all outputs 0 that cycle, no done; a subsequent start completes normally.
- start asserted during SHIFT with different data → ignored; the original result and latency are unchanged.
